// File: rtl/rgb_hue_prep_if.sv
// Pixel-in / divider-request / side-band bundle for the hue front end.
// master drives the RGB stream; slave is the prep block producing div_* and side_*.
interface rgb_hue_prep_if #(
  parameter int unsigned DW   = 8,
  parameter int unsigned FRAC = 8
);
  localparam int unsigned DVW = DW + FRAC;

  logic           in_valid;
  logic [DW-1:0]  in_r;
  logic [DW-1:0]  in_g;
  logic [DW-1:0]  in_b;

  logic           div_valid;
  logic [DVW-1:0] div_dividend;
  logic [DW-1:0]  div_divisor;

  logic           side_valid;
  logic [2:0]     side_sector;
  logic           side_dir;
  logic [DW-1:0]  side_vmax;
  logic [DW-1:0]  side_delta;
  logic           side_gray;

  modport master (
    output in_valid, in_r, in_g, in_b,
    input  div_valid, div_dividend, div_divisor,
    input  side_valid, side_sector, side_dir, side_vmax, side_delta, side_gray
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b,
    output div_valid, div_dividend, div_divisor,
    output side_valid, side_sector, side_dir, side_vmax, side_delta, side_gray
  );
endinterface

// File: rtl/rgb_hue_prep.sv
// Hue front end: max/min/sector extraction feeding the pipelined divider, with
// sector/V/delta side-band delayed to line up with the divider's output.
module rgb_hue_prep #(
  parameter int unsigned DW      = 8,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic         clk,
  input  logic         resetn,
  rgb_hue_prep_if.slave bus
);
  localparam int unsigned DVW = DW + FRAC;

  typedef enum logic [1:0] {SEL_R = 2'd0, SEL_G = 2'd1, SEL_B = 2'd2} sel_e;

  typedef struct packed {
    logic          valid;
    logic [2:0]    sector;
    logic          dir;
    logic [DW-1:0] vmax;
    logic [DW-1:0] delta;
    logic          gray;
  } side_t;

  // Stage 1 registers
  logic          s1_valid_q;
  sel_e          s1_sel_q, s1_sel_d;
  logic [DW-1:0] s1_max_q, s1_max_d;
  logic [DW-1:0] s1_min_q, s1_min_d;
  logic [DW-1:0] s1_r_q, s1_g_q, s1_b_q;

  // Stage 2 registers
  side_t          s2_side_q, s2_side_d;
  logic [DVW-1:0] div_dividend_q, div_dividend_d;
  logic [DW-1:0]  div_divisor_q, div_divisor_d;

  side_t side_q [DIV_LAT];

  // Max select with R>G>B priority on ties
  always_comb begin
    s1_sel_d = SEL_B;
    s1_max_d = bus.in_b;
    if (bus.in_r >= bus.in_g && bus.in_r >= bus.in_b) begin
      s1_sel_d = SEL_R;
      s1_max_d = bus.in_r;
    end else if (bus.in_g >= bus.in_b) begin
      s1_sel_d = SEL_G;
      s1_max_d = bus.in_g;
    end
    s1_min_d = bus.in_r;
    if (bus.in_g < s1_min_d) s1_min_d = bus.in_g;
    if (bus.in_b < s1_min_d) s1_min_d = bus.in_b;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= SEL_R;
      s1_max_q   <= '0;
      s1_min_q   <= '0;
      s1_r_q     <= '0;
      s1_g_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= bus.in_valid;
      s1_sel_q   <= s1_sel_d;
      s1_max_q   <= s1_max_d;
      s1_min_q   <= s1_min_d;
      s1_r_q     <= bus.in_r;
      s1_g_q     <= bus.in_g;
      s1_b_q     <= bus.in_b;
    end
  end

  // Sector/direction/diff; diff never exceeds delta so the dividend cannot overflow
  logic [DW-1:0] delta_c;
  logic [DW-1:0] diff_c;
  logic [2:0]    sector_c;
  logic          dir_c;

  always_comb begin
    delta_c  = s1_max_q - s1_min_q;
    diff_c   = '0;
    sector_c = 3'd0;
    dir_c    = 1'b1;
    case (s1_sel_q)
      SEL_R: begin
        if (s1_g_q >= s1_b_q) begin sector_c = 3'd0; dir_c = 1'b1; diff_c = s1_g_q - s1_b_q; end
        else                  begin sector_c = 3'd5; dir_c = 1'b0; diff_c = s1_b_q - s1_g_q; end
      end
      SEL_G: begin
        if (s1_b_q >= s1_r_q) begin sector_c = 3'd2; dir_c = 1'b1; diff_c = s1_b_q - s1_r_q; end
        else                  begin sector_c = 3'd1; dir_c = 1'b0; diff_c = s1_r_q - s1_b_q; end
      end
      default: begin
        if (s1_r_q >= s1_g_q) begin sector_c = 3'd4; dir_c = 1'b1; diff_c = s1_r_q - s1_g_q; end
        else                  begin sector_c = 3'd3; dir_c = 1'b0; diff_c = s1_g_q - s1_r_q; end
      end
    endcase

    s2_side_d.valid  = s1_valid_q;
    s2_side_d.sector = sector_c;
    s2_side_d.dir    = dir_c;
    s2_side_d.vmax   = s1_max_q;
    s2_side_d.delta  = delta_c;
    s2_side_d.gray   = (delta_c == '0);
    div_dividend_d   = DVW'(diff_c) << FRAC;
    div_divisor_d    = delta_c;

    // Gray pixel: never issue a divide by zero
    if (delta_c == '0) begin
      s2_side_d.sector = 3'd0;
      s2_side_d.dir    = 1'b1;
      div_dividend_d   = '0;
      div_divisor_d    = DW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_side_q      <= '0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
    end else begin
      s2_side_q      <= s2_side_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
    end
  end

  // Free-running side-band delay matching the divider latency
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < DIV_LAT; k++) side_q[k] <= '0;
    end else begin
      side_q[0] <= s2_side_q;
      for (int unsigned k = 1; k < DIV_LAT; k++) side_q[k] <= side_q[k-1];
    end
  end

  assign bus.div_valid    = s2_side_q.valid;
  assign bus.div_dividend = div_dividend_q;
  assign bus.div_divisor  = div_divisor_q;

  assign bus.side_valid   = side_q[DIV_LAT-1].valid;
  assign bus.side_sector  = side_q[DIV_LAT-1].sector;
  assign bus.side_dir     = side_q[DIV_LAT-1].dir;
  assign bus.side_vmax    = side_q[DIV_LAT-1].vmax;
  assign bus.side_delta   = side_q[DIV_LAT-1].delta;
  assign bus.side_gray    = side_q[DIV_LAT-1].gray;

endmodule
